rr_arbiter: RTL

Parameterized round-robin arbiter that shares one resource between N requesters using a registered one-hot grant. It drives the `grant`/`request` pair carried by the arbiter interface. It provides bounded grant hold so that no requester starves, and hands off back-to-back with no dead cycle.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Widest requester vector the helper can build; callers cast down to N.
    localparam int ONEHOT_MAX = 64;

    function automatic logic [ONEHOT_MAX-1:0] onehot_of(input int idx, input int n);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < ONEHOT_MAX) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of (req & mask) scanning up from ptr with wrap.
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic [N-1:0]   mask,
    output logic           found,
    output logic [IDW-1:0] idx
);
    import arb_pkg::*;

    logic [N-1:0]   cand_req;
    logic [IDW-1:0] cand;

    assign cand_req = req & mask;

    // Scan from the far end so the last hit kept is the one closest to ptr.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IDW'((int'(ptr) + i) % N);
            if (cand_req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, bounded hold and zero-gap handoff.
// Supports up to arb_pkg::ONEHOT_MAX requesters.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 2,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   request,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic           gv_q;

    logic [IDW-1:0] pick_ptr;
    logic [N-1:0]   pick_mask;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   pick_oh;

    logic [N-1:0]   owner_oh;
    logic [IDW-1:0] owner_nxt;
    logic           owner_req;
    logic           others_req;
    logic           hold_sat;

    assign owner_oh   = N'(onehot_of(int'(gid_q), N));
    assign owner_nxt  = (int'(gid_q) == N - 1) ? '0 : gid_q + IDW'(1);
    assign owner_req  = request[gid_q];
    assign others_req = |(request & ~owner_oh);
    assign hold_sat   = (hold_q == HW'(MAX_HOLD));
    assign pick_oh    = N'(onehot_of(int'(pick_idx), N));

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (request),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        gid_d     = gid_q;
        pick_ptr  = ptr_q;
        pick_mask = '1;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWNED;
                    grant_d = pick_oh;
                    gid_d   = pick_idx;
                    hold_d  = HW'(1);
                end
            end

            OWNED: begin
                // Masking the owner is harmless on release since its request is already low.
                pick_ptr  = owner_nxt;
                pick_mask = ~owner_oh;
                if (!owner_req) begin
                    ptr_d = owner_nxt;
                    if (pick_found) begin
                        grant_d = pick_oh;
                        gid_d   = pick_idx;
                        hold_d  = HW'(1);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        gid_d   = '0;
                        hold_d  = '0;
                    end
                end else if (hold_sat && others_req) begin
                    ptr_d   = owner_nxt;
                    grant_d = pick_oh;
                    gid_d   = pick_idx;
                    hold_d  = HW'(1);
                end else if (!hold_sat) begin
                    hold_d = hold_q + HW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                gid_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            gid_q   <= '0;
            gv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            gv_q    <= |grant_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = gid_q;
    assign grant_valid = gv_q;

endmodule
